multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 26 ++
 rtl/multicycle_ctrl_decoder.sv | 29 ++
 rtl/multicycle_ctrl.sv | 118 +++++++++++
 tb/tb_multicycle_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle instruction controller.
package multicycle_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0101;

    localparam logic [6:0]      OPC_RTYPE = 7'b0110011;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// InstructionDecoder: maps R-type opcode/funct fields to an ALU op and a RegWrite (legal) flag.
module multicycle_ctrl_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_b5,
    output logic [ALU_OP_W-1:0] alu_op_c,
    output logic                reg_write_c
);

    // Only R-type writes the register file; everything else is reported as illegal.
    always_comb begin
        alu_op_c    = ALU_ADD;
        reg_write_c = 1'b0;
        if (opcode == OPC_RTYPE) begin
            reg_write_c = 1'b1;
            case (funct3)
                3'b000:  alu_op_c = funct7_b5 ? ALU_SUB : ALU_ADD;
                3'b111:  alu_op_c = ALU_AND;
                3'b110:  alu_op_c = ALU_OR;
                3'b100:  alu_op_c = ALU_XOR;
                3'b010:  alu_op_c = ALU_SLT;
                default: alu_op_c = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/WB controller with illegal-instruction trap and retire counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     ir,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                rf_re,
    output logic                alu_en,
    output logic                rf_we,
    input  logic                trap_clr,
    output logic                illegal,
    output logic                busy,
    output logic [CNT_W-1:0]    retired_cnt
);

    state_t              state;
    state_t              state_nxt;
    logic [ALU_OP_W-1:0] dec_alu_op_c;
    logic                dec_legal_c;

    multicycle_ctrl_decoder u_decoder (
        .opcode      (ir[6:0]),
        .funct3      (ir[14:12]),
        .funct7_b5   (ir[30]),
        .alu_op_c    (dec_alu_op_c),
        .reg_write_c (dec_legal_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and strobes, decoded from the registered state only.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        rf_re     = 1'b0;
        alu_en    = 1'b0;
        rf_we     = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                rf_re     = 1'b1;
                state_nxt = dec_legal_c ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                alu_en    = 1'b1;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                rf_we     = 1'b1;
                state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                busy = 1'b0;
                if (trap_clr) state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: instruction latch, decoded op, trap flag, PC and retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            ir          <= '0;
            alu_op      <= '0;
            illegal     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) ir <= imem_rdata;
                end
                ST_DECODE: begin
                    alu_op <= dec_alu_op_c;
                    if (!dec_legal_c) illegal <= 1'b1;
                end
                ST_WB: begin
                    pc          <= pc + PC_STEP;
                    retired_cnt <= retired_cnt + CNT_W'(1);
                end
                ST_TRAP: begin
                    if (trap_clr) illegal <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected retire/trap events, a monitor checks them.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        trap_clr;

    logic        imem_req, rf_re, alu_en, rf_we, illegal, busy;
    logic [31:0] pc, ir, retired_cnt;
    logic [3:0]  alu_op;

    logic        imem_req2, rf_re2, alu_en2, rf_we2, illegal2, busy2;
    logic [31:0] pc2, ir2, retired_cnt2;
    logic [3:0]  alu_op2;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .ir(ir), .alu_op(alu_op), .rf_re(rf_re),
        .alu_en(alu_en), .rf_we(rf_we), .trap_clr(trap_clr), .illegal(illegal),
        .busy(busy), .retired_cnt(retired_cnt)
    );

    multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run), .imem_req(imem_req2), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc2), .ir(ir2), .alu_op(alu_op2), .rf_re(rf_re2),
        .alu_en(alu_en2), .rf_we(rf_we2), .trap_clr(trap_clr), .illegal(illegal2),
        .busy(busy2), .retired_cnt(retired_cnt2)
    );

    typedef struct {
        int          kind;   // 0 = retire, 1 = trap
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] cnt;
        int          lat;
        int          req;
    } exp_t;

    typedef struct {
        int          dly;
        logic [31:0] word;
    } mem_t;

    exp_t sb_q[$];
    mem_t mem_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: acks the head of mem_q after its programmed number of wait cycles.
    int wait_cnt = 0;
    always @(negedge clk) begin
        imem_ack = 1'b0;
        if (!rst_n) begin
            wait_cnt = 0;
        end else if (imem_req && mem_q.size() > 0) begin
            if (wait_cnt < mem_q[0].dly) begin
                wait_cnt++;
            end else begin
                imem_ack   = 1'b1;
                imem_rdata = mem_q[0].word;
                void'(mem_q.pop_front());
                wait_cnt   = 0;
            end
        end
    end

    // Monitor: tracks fetch timing and pops the scoreboard on every retire or trap entry.
    int          cyc = 0;
    int          fetch_start = 0;
    int          req_cycles = 0;
    int          re_cyc = -10;
    int          alu_cyc = -10;
    logic        prev_req = 1'b0;
    logic        prev_ill = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    exp_t        e;
    always @(negedge clk) begin
        cyc++;
        if (rf_re | alu_en | rf_we)
            chk("one_strobe", 32'(rf_re) + 32'(alu_en) + 32'(rf_we), 32'd1);
        if (imem_req) begin
            if (!prev_req) begin
                fetch_start = cyc;
                req_cycles  = 0;
            end else begin
                chk("pc_stable_fetch", pc, prev_pc);
            end
            req_cycles++;
        end
        if (rf_re)  re_cyc  = cyc;
        if (alu_en) alu_cyc = cyc;
        if (rf_we) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_retire: got retire at pc %h expected none", pc);
            end else begin
                e = sb_q.pop_front();
                chk("event_kind_retire", 32'(0), 32'(e.kind));
                chk("alu_op", 32'(alu_op), 32'(e.op));
                chk("pc_at_wb", pc, e.pc);
                chk("cnt_at_wb", retired_cnt, e.cnt);
                chk("latency", 32'(cyc - fetch_start + 1), 32'(e.lat));
                chk("req_cycles", 32'(req_cycles), 32'(e.req));
                chk("alu_en_slot", 32'(cyc - alu_cyc), 32'd1);
                chk("rf_re_slot", 32'(cyc - re_cyc), 32'd2);
            end
        end
        if (illegal && !prev_ill) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_trap: got trap at pc %h expected none", pc);
            end else begin
                e = sb_q.pop_front();
                chk("event_kind_trap", 32'(1), 32'(e.kind));
                chk("pc_at_trap", pc, e.pc);
                chk("cnt_at_trap", retired_cnt, e.cnt);
                chk("busy_in_trap", 32'(busy), 32'd0);
            end
        end
        prev_req = imem_req;
        prev_ill = illegal;
        prev_pc  = pc;
    end

    // Bounded wait on a DUT condition, sampled at negedge.
    task automatic wait_for(input int sel, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = alu_en;
                1:       hit = !busy;
                2:       hit = illegal;
                default: hit = imem_req;
            endcase
            if (hit) break;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL timeout_%s: got no event expected within 100 cycles", name);
        end
    endtask

    // One legal instruction; run is dropped during EXEC so WB returns to IDLE.
    task automatic run_one(input logic [31:0] word, input int dly, input logic [3:0] op,
                           input logic [31:0] epc, input logic [31:0] ecnt, input int lat);
        mem_q.push_back('{dly, word});
        sb_q.push_back('{0, op, epc, ecnt, lat, dly + 1});
        run = 1'b1;
        wait_for(0, "exec");
        run = 1'b0;
        wait_for(1, "idle");
    endtask

    logic [31:0] words[4] = '{32'h0020_F1B3, 32'h0020_E1B3, 32'h0020_C1B3, 32'h0020_A1B3};
    logic [3:0]  ops[4]   = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SLT};
    int          dlys[4]  = '{0, 1, 2, 0};

    initial begin
        rst_n = 1'b0; run = 1'b0; trap_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_cnt", retired_cnt, 32'h0);
        chk("rst_strobes", {28'h0, imem_req, rf_re, alu_en, rf_we}, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pc2", pc2, 32'hFFFF_FFFC);

        // add, ack in first FETCH cycle, released from reset with run=1
        rst_n = 1'b1;
        run_one(32'h0020_81B3, 0, ALU_ADD, 32'h0, 32'h0, 4);
        chk("add_pc", pc, 32'h4);
        chk("add_cnt", retired_cnt, 32'h1);
        chk("add_busy", 32'(busy), 32'h0);
        chk("wrap_pc2", pc2, 32'h0);
        chk("wrap_cnt2", retired_cnt2, 32'h1);

        // sub with three wait cycles; trap_clr held high must be ignored outside TRAP
        trap_clr = 1'b1;
        run_one(32'h4020_81B3, 3, ALU_SUB, 32'h4, 32'h1, 7);
        trap_clr = 1'b0;
        chk("sub_pc", pc, 32'h8);
        chk("sub_cnt", retired_cnt, 32'h2);

        // addi is not R-type -> trap, pc and count frozen
        mem_q.push_back('{0, 32'h0000_0013});
        sb_q.push_back('{1, ALU_ADD, 32'h8, 32'h2, 0, 0});
        run = 1'b1;
        wait_for(2, "trap");
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("trap_illegal", 32'(illegal), 32'h1);
        chk("trap_pc", pc, 32'h8);
        chk("trap_cnt", retired_cnt, 32'h2);
        chk("trap_busy", 32'(busy), 32'h0);
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        chk("clr_illegal", 32'(illegal), 32'h0);
        chk("clr_busy", 32'(busy), 32'h0);
        chk("clr_pc", pc, 32'h8);

        // remaining ALU ops, refetching from the faulting pc
        for (int i = 0; i < 4; i++)
            run_one(words[i], dlys[i], ops[i], 32'h8 + 32'(4 * i), 32'(2 + i), 4 + dlys[i]);
        chk("final_pc", pc, 32'd24);
        chk("final_cnt", retired_cnt, 32'd6);

        // asynchronous reset in the middle of a fetch
        run = 1'b1;
        wait_for(3, "fetch");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", 32'(imem_req), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_pc", pc, 32'h0);
        chk("async_ir", ir, 32'h0);
        chk("async_alu_op", 32'(alu_op), 32'h0);
        chk("async_cnt", retired_cnt, 32'h0);
        chk("async_pc2", pc2, 32'hFFFF_FFFC);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("async_idle_req", 32'(imem_req), 32'h0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
